mem_arbiter: RTL and testbench

- Two-port arbiter/sequencer that shares the single RISC240 memorySystem bus between requester 0 (CPU datapath FSM) and requester 1 (debug loader/DMA port).
- Converts each requester's req/ack single-word transactions into correctly timed address, read-enable, write-enable and tristate-data activity on the memory bus.
- Grant is round-robin, with an optional bounded lock for read-modify-write sequences.
- Sits between the requesters and memorySystem; it is the only driver of the memory-side address and enable signals.

---
 rtl/mem_arbiter_pkg.sv | 7 +
 rtl/mem_arbiter_rr_grant2.sv | 29 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared memory-bus enables and arbiter state encodings
package mem_arbiter_pkg;
    typedef enum logic {MEM_WR = 1'b0, MEM_NO_WR = 1'b1} wr_enable_t;
    typedef enum logic {MEM_RD = 1'b0, MEM_NO_RD = 1'b1} rd_enable_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_ACK} arb_state_t;
    localparam int WORD_W = 16;
endpackage

// File: rtl/mem_arbiter_rr_grant2.sv
// rr_grant2: two-input round-robin/fixed-priority picker with lock override
module rr_grant2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       lock_hold,
    input  logic       upd,
    input  logic       upd_grant,
    output logic       grant,
    output logic       last_grant
);
    logic last_grant_q, last_grant_d;
    // remember the requester served most recently
    always_comb last_grant_d = upd ? upd_grant : last_grant_q;
    // last_grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clock) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end
    // a held lock keeps the previous owner, otherwise priority or rotation breaks ties
    always_comb begin
        grant = (req == 2'b10) ? 1'b1 :
                (req == 2'b11) ? (lock_hold ? last_grant_q : ((FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q)) :
                1'b0;
        last_grant = last_grant_q;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences two req/ack requesters onto the single memory bus
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX   = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [1:0]        lock,
    input  logic [WORD_W-1:0] addr0,
    input  logic [WORD_W-1:0] addr1,
    input  logic [WORD_W-1:0] wdata0,
    input  logic [WORD_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [WORD_W-1:0] rdata0,
    output logic [WORD_W-1:0] rdata1,
    output logic [WORD_W-1:0] mem_address,
    inout  wire  [WORD_W-1:0] mem_data,
    output wr_enable_t        mem_we_L,
    output rd_enable_t        mem_re_L
);
    localparam logic [7:0] LMAX = 8'(LOCK_MAX);

    arb_state_t        state_q, state_d;
    logic              g_q, g_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [WORD_W-1:0] addr_g, wdata_g;
    logic              we_g, grant, last_grant, lock_hold, drive;

    rr_grant2 #(.FIXED_PRIO(FIXED_PRIO)) u_grant (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .lock_hold (lock_hold),
        .upd       (state_q == ARB_ACK),
        .upd_grant (g_q),
        .grant     (grant),
        .last_grant(last_grant)
    );

    // select the granted requester's transaction and decide whether its lock still holds
    always_comb begin
        addr_g    = g_q ? addr1 : addr0;
        wdata_g   = g_q ? wdata1 : wdata0;
        we_g      = we[g_q];
        lock_hold = (cnt_q != 8'd0) && (cnt_q < LMAX) && req[last_grant];
    end

    // state register; reset also aborts an in-flight access
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            g_q      <= 1'b0;
            cnt_q    <= 8'd0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // next state: arbitrate in IDLE, capture read data in ACCESS, account lock in ACK
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            ARB_IDLE: begin
                state_d = (|req) ? ARB_ACCESS : ARB_IDLE;
                g_d     = (|req) ? grant : g_q;
                cnt_d   = (cnt_q == LMAX || !req[last_grant]) ? 8'd0 : cnt_q;
            end
            ARB_ACCESS: begin
                state_d  = ARB_ACK;
                rdata0_d = (!we_g && !g_q) ? mem_data : rdata0_q;
                rdata1_d = (!we_g && g_q) ? mem_data : rdata1_q;
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
                cnt_d   = lock[g_q] ? cnt_q + 8'd1 : 8'd0;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // bus outputs; gating with reset kills a write in the very cycle reset is seen
    always_comb begin
        ack         = (state_q == ARB_ACK && !reset) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
        mem_address = (state_q == ARB_ACCESS && !reset) ? addr_g : '0;
        mem_re_L    = (state_q == ARB_ACCESS && !we_g && !reset) ? MEM_RD : MEM_NO_RD;
        mem_we_L    = (state_q == ARB_ACCESS && we_g && !reset) ? MEM_WR : MEM_NO_WR;
        drive       = (state_q == ARB_ACCESS) && we_g && !reset;
        rdata0      = rdata0_q;
        rdata1      = rdata1_q;
    end

    assign mem_data = drive ? wdata_g : 'z;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random-traffic checks of mem_arbiter against a memory model
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clock = 1'b0, reset = 1'b1, mem_init = 1'b1, hyg_en = 1'b0;
    logic [1:0]  req = '0, we = '0, lock = '0, ack;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [15:0] rdata0, rdata1, mem_address;
    wire  [15:0] mem_data;
    wr_enable_t  mem_we_L;
    rd_enable_t  mem_re_L;
    logic [15:0] mem [4096];
    int          n_checks = 0, n_pass = 0, cyc = 0, viol = 0;

    mem_arbiter #(.LOCK_MAX(3), .FIXED_PRIO(0)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .lock(lock),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata0(rdata0), .rdata1(rdata1), .mem_address(mem_address),
        .mem_data(mem_data), .mem_we_L(mem_we_L), .mem_re_L(mem_re_L)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // memory model: async read, write on posedge; word 0x0010 preloaded with 0xBEEF
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
            mem[8] <= 16'hBEEF;
        end else if (mem_we_L == MEM_WR) begin
            mem[mem_address[12:1]] <= mem_data;
        end
    end
    // the bench parks the bus at 0 when idle, so any stray DUT drive shows up as non-zero
    assign mem_data = (mem_re_L == MEM_RD) ? mem[mem_address[12:1]] :
                      (mem_we_L == MEM_WR) ? 16'hzzzz : 16'h0000;

    always @(negedge clock) if (hyg_en) begin
        if (mem_we_L == MEM_WR && mem_re_L == MEM_RD) viol++;
        if (mem_we_L != MEM_WR && mem_re_L != MEM_RD && mem_data !== 16'h0000) viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(output logic [1:0] a, output int c);
        a = 2'b00;
        c = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack != 2'b00) begin
                a = ack;
                c = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        req = '0; lock = '0; we = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++; if (ack !== 2'b00) $display("FAIL reset_ack got %h want 0", ack); else n_pass++;
        n_checks++; if (rdata0 !== 16'h0) $display("FAIL reset_rdata0 got %h want 0", rdata0); else n_pass++;
        n_checks++; if (rdata1 !== 16'h0) $display("FAIL reset_rdata1 got %h want 0", rdata1); else n_pass++;
        n_checks++; if (mem_we_L !== MEM_NO_WR) $display("FAIL reset_we got %b want %b", mem_we_L, MEM_NO_WR); else n_pass++;
        n_checks++; if (mem_re_L !== MEM_NO_RD) $display("FAIL reset_re got %b want %b", mem_re_L, MEM_NO_RD); else n_pass++;
        n_checks++; if (mem_address !== 16'h0) $display("FAIL reset_addr got %h want 0", mem_address); else n_pass++;
        reset = 1'b0;
        mem_init = 1'b0;
        hyg_en = 1'b1;
    endtask

    task automatic test_single_read();
        addr0 = 16'h0010; we[0] = 1'b0; req[0] = 1'b1;
        tick();
        n_checks++; if (mem_re_L !== MEM_RD) $display("FAIL rd_re got %b want %b", mem_re_L, MEM_RD); else n_pass++;
        n_checks++; if (mem_we_L !== MEM_NO_WR) $display("FAIL rd_we got %b want %b", mem_we_L, MEM_NO_WR); else n_pass++;
        n_checks++; if (mem_address !== 16'h0010) $display("FAIL rd_addr got %h want 0010", mem_address); else n_pass++;
        n_checks++; if (ack !== 2'b00) $display("FAIL rd_early_ack got %b want 00", ack); else n_pass++;
        tick();
        n_checks++; if (ack !== 2'b01) $display("FAIL rd_ack got %b want 01", ack); else n_pass++;
        n_checks++; if (rdata0 !== 16'hBEEF) $display("FAIL rd_rdata0 got %h want beef", rdata0); else n_pass++;
        req[0] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_write_read();
        int c0;
        addr1 = 16'h0400; wdata1 = 16'h1234; we[1] = 1'b1; req[1] = 1'b1;
        tick();
        n_checks++; if (mem_we_L !== MEM_WR) $display("FAIL wr_we got %b want %b", mem_we_L, MEM_WR); else n_pass++;
        n_checks++; if (mem_re_L !== MEM_NO_RD) $display("FAIL wr_re got %b want %b", mem_re_L, MEM_NO_RD); else n_pass++;
        n_checks++; if (mem_data !== 16'h1234) $display("FAIL wr_data got %h want 1234", mem_data); else n_pass++;
        n_checks++; if (mem_address !== 16'h0400) $display("FAIL wr_addr got %h want 0400", mem_address); else n_pass++;
        tick();
        n_checks++; if (ack !== 2'b10) $display("FAIL wr_ack got %b want 10", ack); else n_pass++;
        c0 = cyc;
        we[1] = 1'b0;
        repeat (2) tick();
        n_checks++; if (mem_re_L !== MEM_RD) $display("FAIL wr_rd_re got %b want %b", mem_re_L, MEM_RD); else n_pass++;
        n_checks++; if (mem_data !== 16'h1234) $display("FAIL wr_rd_bus got %h want 1234", mem_data); else n_pass++;
        tick();
        n_checks++; if (ack !== 2'b10) $display("FAIL wr_rd_ack got %b want 10", ack); else n_pass++;
        n_checks++; if (rdata1 !== 16'h1234) $display("FAIL wr_rd_rdata1 got %h want 1234", rdata1); else n_pass++;
        n_checks++; if (cyc - c0 !== 3) $display("FAIL wr_rd_spacing got %0d want 3", cyc - c0); else n_pass++;
        req[1] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0] a;
        int c, prev;
        pulse_reset();
        addr0 = 16'h0010; addr1 = 16'h0400; we = 2'b00; req = 2'b11;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, c);
            n_checks++; if (a !== exp_g[k]) $display("FAIL rr_grant%0d got %b want %b", k, a, exp_g[k]); else n_pass++;
            if (k > 0) begin
                n_checks++; if (c - prev !== 3) $display("FAIL rr_spacing%0d got %0d want 3", k, c - prev); else n_pass++;
            end
            prev = c;
        end
        req = 2'b00;
        repeat (2) tick();
        n_checks++; if (rdata0 !== 16'hBEEF) $display("FAIL rr_rdata0 got %h want beef", rdata0); else n_pass++;
        n_checks++; if (rdata1 !== 16'h1234) $display("FAIL rr_rdata1 got %h want 1234", rdata1); else n_pass++;
    endtask

    task automatic test_lock();
        logic [1:0] exp_g [5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        logic [1:0] a;
        int c;
        pulse_reset();
        addr0 = 16'h0010; addr1 = 16'h0400; we = 2'b00; lock = 2'b01; req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a, c);
            n_checks++; if (a !== exp_g[k]) $display("FAIL lock_grant%0d got %b want %b", k, a, exp_g[k]); else n_pass++;
        end
        req = 2'b00; lock = 2'b00;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] a;
        int c;
        logic seen;
        pulse_reset();
        addr0 = 16'h0420; wdata0 = 16'h5555; we[0] = 1'b1; req[0] = 1'b1;
        tick();
        n_checks++; if (mem_we_L !== MEM_WR) $display("FAIL rst_pre_we got %b want %b", mem_we_L, MEM_WR); else n_pass++;
        reset = 1'b1; req = 2'b00;
        #1;
        n_checks++; if (mem_we_L !== MEM_NO_WR) $display("FAIL rst_mid_we got %b want %b", mem_we_L, MEM_NO_WR); else n_pass++;
        n_checks++; if (mem_re_L !== MEM_NO_RD) $display("FAIL rst_mid_re got %b want %b", mem_re_L, MEM_NO_RD); else n_pass++;
        seen = (ack != 2'b00);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack != 2'b00) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst_no_ack got %b want 0", seen); else n_pass++;
        n_checks++; if (mem[12'h210] !== 16'h0000) $display("FAIL rst_mem got %h want 0000", mem[12'h210]); else n_pass++;
        addr0 = 16'h0010; we[0] = 1'b0; req[0] = 1'b1;
        wait_ack(a, c);
        req[0] = 1'b0;
        n_checks++; if (rdata0 !== 16'hBEEF) $display("FAIL rst_rd1 got %h want beef", rdata0); else n_pass++;
        tick();
        addr0 = 16'h0420; req[0] = 1'b1;
        wait_ack(a, c);
        req[0] = 1'b0;
        n_checks++; if (a !== 2'b01) $display("FAIL rst_rd2_ack got %b want 01", a); else n_pass++;
        n_checks++; if (rdata0 !== 16'h0000) $display("FAIL rst_rd2 got %h want 0000", rdata0); else n_pass++;
        repeat (2) tick();
    endtask

    task automatic test_bus_hygiene();
        logic [15:0] shadow [32];
        logic        act [2], twe [2];
        logic [4:0]  tix [2];
        logic [15:0] twd [2], rd;
        int          done, guard;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        for (int p = 0; p < 2; p++) begin act[p] = 1'b0; twe[p] = 1'b0; tix[p] = '0; twd[p] = '0; end
        done = 0;
        guard = 0;
        while (done < 1000 && guard < 20000) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && $urandom_range(0, 3) != 0) begin
                    act[p] = 1'b1;
                    twe[p] = 1'($urandom_range(0, 1));
                    tix[p] = 5'($urandom_range(0, 31));
                    twd[p] = 16'($urandom) | 16'h0001;
                end
            end
            req = {act[1], act[0]};
            we = {twe[1], twe[0]};
            addr0 = {10'h004, tix[0], 1'b0};
            addr1 = {10'h004, tix[1], 1'b0};
            wdata0 = twd[0];
            wdata1 = twd[1];
            tick();
            guard++;
            for (int p = 0; p < 2; p++) begin
                if (ack[p]) begin
                    if (!act[p]) viol++;
                    done++;
                    rd = p ? rdata1 : rdata0;
                    if (twe[p]) shadow[tix[p]] = twd[p];
                    else begin
                        n_checks++;
                        if (rd !== shadow[tix[p]]) $display("FAIL hyg_rdata%0d got %h want %h", p, rd, shadow[tix[p]]);
                        else n_pass++;
                    end
                    act[p] = 1'b0;
                end
            end
        end
        req = 2'b00;
        repeat (3) tick();
        n_checks++; if (done < 1000) $display("FAIL hyg_count got %0d want 1000", done); else n_pass++;
        n_checks++; if (viol !== 0) $display("FAIL hyg_bus got %0d violations want 0", viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_lock();
        test_reset_mid_write();
        test_bus_hygiene();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
